// File: rtl/testenc_ap_ctrl_initiator_pkg.sv
// rtl/testenc_ap_ctrl_initiator_pkg.sv - shared types and default constants for the ap_ctrl initiator
// Contents: FSM state type and default parameter values used by the
// initiator top and its watchdog sub-module.
package testenc_ap_ctrl_pkg;

  localparam int CNT_W_DEF        = 16;
  localparam int MAX_INFLIGHT_DEF = 4;
  localparam int TMO_W_DEF        = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/testenc_ap_ctrl_initiator_if.sv
// rtl/testenc_ap_ctrl_initiator_if.sv - block-level ap_ctrl_hs handshake toward a child kernel
// Signals:
//   child_ap_start    : caller -> child, start request
//   child_ap_ready    : child -> caller, start accepted
//   child_ap_done     : child -> caller, invocation complete
//   child_ap_continue : caller -> child, done acknowledged
// Modports: master (the initiator), slave (the child kernel).
interface testenc_ap_ctrl_initiator_if;

  logic child_ap_start;
  logic child_ap_ready;
  logic child_ap_done;
  logic child_ap_continue;

  modport master (
    output child_ap_start,
    output child_ap_continue,
    input  child_ap_ready,
    input  child_ap_done
  );

  modport slave (
    input  child_ap_start,
    input  child_ap_continue,
    output child_ap_ready,
    output child_ap_done
  );

endinterface

// File: rtl/testenc_ap_ctrl_initiator_watchdog.sv
// rtl/testenc_ap_ctrl_initiator_watchdog.sv - idle-progress watchdog for the ap_ctrl initiator
// Ports:
//   ap_clk, ap_rst_n : clock and synchronous active-low reset
//   clear            : restart the count (progress was made this cycle)
//   enable           : count while high, hold at zero while low
//   limit            : expiry threshold, 0 disables expiry
//   expired          : high in the cycle whose edge brings the count to limit
// Only built when TESTENC_AP_CTRL_TIMEOUT_EN is defined.
module testenc_ap_ctrl_watchdog
  import testenc_ap_ctrl_pkg::*;
#(
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_inc;

  // Saturating increment so a long stall cannot wrap back under the limit.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + TMO_W'(1);

  // Fires on the value the counter is about to take, so the FSM leaves at
  // exactly 'limit' edges after the last progress event.
  assign expired = enable && !clear && (limit != '0) && (cnt_inc == limit);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      cnt_q <= '0;
    end else if (clear || !enable) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_inc;
    end
  end

endmodule

// File: rtl/testenc_ap_ctrl_initiator.sv
// rtl/testenc_ap_ctrl_initiator.sv - caller-side ap_ctrl_hs sequencer launching a child kernel run_count times
// Ports:
//   ap_clk, ap_rst_n          : clock and synchronous active-low reset
//   run_valid/run_count       : run request and number of child invocations
//   run_ready                 : request can be accepted (IDLE)
//   run_done                  : one-cycle pulse at end of run
//   run_err                   : spurious done or watchdog expiry in last run
//   busy                      : run in progress
//   child (master modport)    : ap_start/ap_ready/ap_done/ap_continue handshake
//   tmo_limit                 : watchdog limit, 0 disables
//   starts_issued, dones_seen : progress counters of current/last run
// Optional feature: TESTENC_AP_CTRL_TIMEOUT_EN builds the watchdog.
module testenc_ap_ctrl_initiator
  import testenc_ap_ctrl_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int TMO_W        = TMO_W_DEF
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        run_valid,
  input  logic [CNT_W-1:0]            run_count,
  output logic                        run_ready,
  output logic                        run_done,
  output logic                        run_err,
  output logic                        busy,
  testenc_ap_ctrl_initiator_if.master child,
  input  logic [TMO_W-1:0]            tmo_limit,
  output logic [CNT_W-1:0]            starts_issued,
  output logic [CNT_W-1:0]            dones_seen
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IW-1:0] MAX_IF = IW'(MAX_INFLIGHT);

  state_t           state;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] starts_q;
  logic [CNT_W-1:0] dones_q;
  logic [IW-1:0]    inflight_q;
  logic             run_err_q;
  logic             run_ready_q;
  logic             run_done_q;
  logic             busy_q;
  logic             start_q;
  logic             cont_q;

  logic             accept;
  logic             ack;
  logic             spurious;
  logic             ack_valid;
  logic [CNT_W-1:0] starts_n;
  logic [CNT_W-1:0] dones_n;
  logic [IW-1:0]    inflight_n;
  logic             issue_more;
  logic             wd_expired;

  // Datapath next values. start_q/cont_q are only ever high in ISSUE/DRAIN,
  // so accept/ack are already qualified by state.
  always_comb begin
    accept    = start_q & child.child_ap_ready;
    ack       = cont_q & child.child_ap_done;
    spurious  = ack && (inflight_q == '0);
    ack_valid = ack && !spurious;

    starts_n = starts_q;
    if (accept && (starts_q != '1)) starts_n = starts_q + CNT_W'(1);

    dones_n = dones_q;
    if (ack_valid && (dones_q != '1)) dones_n = dones_q + CNT_W'(1);

    // Simultaneous start and done cancel out.
    inflight_n = inflight_q;
    if (accept && !ack_valid) begin
      inflight_n = inflight_q + IW'(1);
    end else if (!accept && ack_valid) begin
      inflight_n = inflight_q - IW'(1);
    end

    // Start request for the next cycle, decided on the updated counters so
    // the registered start can never drop before it has been accepted.
    issue_more = (starts_n < count_q) && (inflight_n < MAX_IF);
  end

`ifdef TESTENC_AP_CTRL_TIMEOUT_EN
  testenc_ap_ctrl_watchdog #(
    .TMO_W (TMO_W)
  ) u_watchdog (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .clear    (accept | ack),
    .enable   (cont_q),
    .limit    (tmo_limit),
    .expired  (wd_expired)
  );
`else
  logic unused_tmo;
  assign unused_tmo = ^tmo_limit;
  assign wd_expired = 1'b0;
`endif

  // Single FSM process; every output is a register set alongside the
  // transition that makes it valid.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state       <= IDLE;
      count_q     <= '0;
      starts_q    <= '0;
      dones_q     <= '0;
      inflight_q  <= '0;
      run_err_q   <= 1'b0;
      run_ready_q <= 1'b1;
      run_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      cont_q      <= 1'b0;
    end else begin
      run_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (run_valid) begin
            count_q     <= run_count;
            starts_q    <= '0;
            dones_q     <= '0;
            inflight_q  <= '0;
            run_err_q   <= 1'b0;
            run_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (run_count == '0) begin
              state      <= FINISH;
              run_done_q <= 1'b1;
            end else begin
              // Nothing in flight and MAX_INFLIGHT >= 1: start at once.
              state   <= ISSUE;
              start_q <= 1'b1;
              cont_q  <= 1'b1;
            end
          end
        end

        ISSUE: begin
          starts_q   <= starts_n;
          dones_q    <= dones_n;
          inflight_q <= inflight_n;
          if (spurious || wd_expired) run_err_q <= 1'b1;
          if (wd_expired) begin
            state      <= FINISH;
            start_q    <= 1'b0;
            cont_q     <= 1'b0;
            run_done_q <= 1'b1;
          end else if (accept && (starts_n == count_q)) begin
            // At least one invocation is still outstanding here, so the
            // run cannot also be complete in this cycle.
            state   <= DRAIN;
            start_q <= 1'b0;
          end else begin
            start_q <= issue_more;
          end
        end

        DRAIN: begin
          starts_q   <= starts_n;
          dones_q    <= dones_n;
          inflight_q <= inflight_n;
          if (spurious || wd_expired) run_err_q <= 1'b1;
          if (wd_expired || (dones_n == count_q)) begin
            state      <= FINISH;
            cont_q     <= 1'b0;
            run_done_q <= 1'b1;
          end
        end

        FINISH: begin
          state       <= IDLE;
          run_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end

        default: begin
          state       <= IDLE;
          run_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          start_q     <= 1'b0;
          cont_q      <= 1'b0;
        end
      endcase
    end
  end

  assign run_ready               = run_ready_q;
  assign run_done                = run_done_q;
  assign run_err                 = run_err_q;
  assign busy                    = busy_q;
  assign child.child_ap_start    = start_q;
  assign child.child_ap_continue = cont_q;
  assign starts_issued           = starts_q;
  assign dones_seen              = dones_q;

endmodule

// File: tb/tb_testenc_ap_ctrl_initiator.sv
// tb/tb_testenc_ap_ctrl_initiator.sv - self-checking bench for the ap_ctrl initiator with a child kernel model
module tb_testenc_ap_ctrl_initiator;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        run_valid;
  logic [15:0] run_count;
  logic        run_ready;
  logic        run_done;
  logic        run_err;
  logic        busy;
  logic [19:0] tmo_limit;
  logic [15:0] starts_issued;
  logic [15:0] dones_seen;

  testenc_ap_ctrl_initiator_if ch ();

  testenc_ap_ctrl_initiator dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .run_valid     (run_valid),
    .run_count     (run_count),
    .run_ready     (run_ready),
    .run_done      (run_done),
    .run_err       (run_err),
    .busy          (busy),
    .child         (ch),
    .tmo_limit     (tmo_limit),
    .starts_issued (starts_issued),
    .dones_seen    (dones_seen)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] starts;
    logic [15:0] dones;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  // Child kernel model
  int   ready_delay = 0;
  int   done_lat    = 3;
  bit   done_en     = 1;
  bit   inject      = 0;
  int   pend_q[$];
  int   acc_cyc[$];
  int   ack_cyc[$];
  int   drops       = 0;
  int   wait_cnt    = 0;
  logic p_start = 0, p_ready = 0, p_done = 0, p_cont = 0;
  bit   p_inj   = 0;

  initial begin
    ch.child_ap_ready = 1'b0;
    ch.child_ap_done  = 1'b0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        pend_q.delete();
        wait_cnt = 0;
        inject = 0;
        ch.child_ap_ready = 1'b0;
        ch.child_ap_done  = 1'b0;
        p_start = 0; p_ready = 0; p_done = 0; p_cont = 0; p_inj = 0;
      end else begin
        if (p_start && p_ready) begin
          acc_cyc.push_back(cyc);
          if (done_en) pend_q.push_back(cyc + done_lat);
          wait_cnt = 0;
        end else if (p_start && !ch.child_ap_start) begin
          drops++;
        end
        if (p_done && p_cont) begin
          if (p_inj) begin
            inject = 0;
          end else begin
            ack_cyc.push_back(cyc);
            if (pend_q.size() > 0) void'(pend_q.pop_front());
          end
        end
        if (ch.child_ap_start) begin
          ch.child_ap_ready = (wait_cnt >= ready_delay);
          wait_cnt++;
        end else begin
          ch.child_ap_ready = 1'b0;
        end
        if (inject) begin
          ch.child_ap_done = 1'b1;
          p_inj = 1;
        end else begin
          ch.child_ap_done = (pend_q.size() > 0) && (pend_q[0] <= cyc);
          p_inj = 0;
        end
        p_start = ch.child_ap_start;
        p_ready = ch.child_ap_ready;
        p_done  = ch.child_ap_done;
        p_cont  = ch.child_ap_continue;
      end
    end
  end

  // Run-completion scoreboard
  logic prev_run_done = 0;
  always @(negedge ap_clk) begin
    if (ap_rst_n && run_done) begin
      checks++;
      if (prev_run_done) begin
        errors++;
        $display("FAIL run_done_width: high for 2+ cycles, required 1");
      end
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_run_done: got pulse, required none at cyc %0d", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        if (starts_issued !== e.starts) begin
          errors++;
          $display("FAIL sb_starts: got %0d required %0d", starts_issued, e.starts);
        end
        checks++;
        if (dones_seen !== e.dones) begin
          errors++;
          $display("FAIL sb_dones: got %0d required %0d", dones_seen, e.dones);
        end
        checks++;
        if (run_err !== e.err) begin
          errors++;
          $display("FAIL sb_err: got %0b required %0b", run_err, e.err);
        end
      end
    end
    prev_run_done = ap_rst_n && run_done;
  end

  task automatic request(input int cnt, input bit push,
                         input logic [15:0] es, input logic [15:0] ed, input logic ee);
    @(negedge ap_clk);
    run_valid = 1'b1;
    run_count = cnt[15:0];
    if (push) sb_q.push_back('{starts: es, dones: ed, err: ee});
    @(posedge ap_clk);
    #1;
    run_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string name);
    bit got = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge ap_clk);
      if (run_done) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: no run_done within %0d cycles", name, max_cyc);
    end
    @(posedge ap_clk);
    #1;
  endtask

  task automatic test_reset;
    ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    checks++; if (run_ready !== 1'b1) begin errors++; $display("FAIL rst_run_ready: got %b required 1", run_ready); end
    checks++; if (run_done !== 1'b0) begin errors++; $display("FAIL rst_run_done: got %b required 0", run_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (run_err !== 1'b0) begin errors++; $display("FAIL rst_run_err: got %b required 0", run_err); end
    checks++; if (ch.child_ap_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b required 0", ch.child_ap_start); end
    checks++; if (ch.child_ap_continue !== 1'b0) begin errors++; $display("FAIL rst_continue: got %b required 0", ch.child_ap_continue); end
    checks++; if (starts_issued !== 16'd0) begin errors++; $display("FAIL rst_starts: got %0d required 0", starts_issued); end
    checks++; if (dones_seen !== 16'd0) begin errors++; $display("FAIL rst_dones: got %0d required 0", dones_seen); end
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic test_spurious;
    ready_delay = 3; done_lat = 2;
    request(2, 1, 16'd2, 16'd2, 1'b1);
    inject = 1;
    @(posedge ap_clk);
    #1;
    checks++; if (dones_seen !== 16'd0) begin errors++; $display("FAIL spur_dones: got %0d required 0", dones_seen); end
    checks++; if (run_err !== 1'b1) begin errors++; $display("FAIL spur_err: got %b required 1", run_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL spur_busy: got %b required 1", busy); end
    wait_done(80, "spur");
    checks++; if (run_err !== 1'b1) begin errors++; $display("FAIL spur_err_held: got %b required 1", run_err); end
  endtask

  task automatic test_zero_count;
    request(0, 1, 16'd0, 16'd0, 1'b0);
    @(negedge ap_clk);
    checks++; if (run_done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b required 1", run_done); end
    checks++; if (run_ready !== 1'b0) begin errors++; $display("FAIL zero_ready_t1: got %b required 0", run_ready); end
    checks++; if (ch.child_ap_start !== 1'b0) begin errors++; $display("FAIL zero_start: got %b required 0", ch.child_ap_start); end
    @(negedge ap_clk);
    checks++; if (run_ready !== 1'b1) begin errors++; $display("FAIL zero_ready_t2: got %b required 1", run_ready); end
    checks++; if (run_done !== 1'b0) begin errors++; $display("FAIL zero_done_t2: got %b required 0", run_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_t2: got %b required 0", busy); end
  endtask

  task automatic test_back_to_back;
    acc_cyc.delete(); ack_cyc.delete();
    ready_delay = 0; done_lat = 3;
    request(5, 1, 16'd5, 16'd5, 1'b0);
    wait_done(80, "b2b");
    checks++;
    if (acc_cyc.size() != 5 || ack_cyc.size() != 5) begin
      errors++;
      $display("FAIL b2b_counts: starts %0d dones %0d required 5 and 5", acc_cyc.size(), ack_cyc.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != 1) begin
          errors++;
          $display("FAIL b2b_gap%0d: got %0d required 1", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
      checks++;
      if (acc_cyc[4] != ack_cyc[0] + 1) begin
        errors++;
        $display("FAIL b2b_fifth: start at %0d required %0d", acc_cyc[4], ack_cyc[0] + 1);
      end
    end
  endtask

  task automatic test_ready_stall;
    acc_cyc.delete();
    drops = 0; ready_delay = 7; done_lat = 2;
    request(3, 1, 16'd3, 16'd3, 1'b0);
    wait_done(120, "stall");
    checks++; if (drops != 0) begin errors++; $display("FAIL stall_drops: got %0d required 0", drops); end
    checks++;
    if (acc_cyc.size() != 3) begin
      errors++;
      $display("FAIL stall_accepts: got %0d required 3", acc_cyc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != 8) begin
          errors++;
          $display("FAIL stall_gap%0d: got %0d required 8", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_overlap;
    int hits = 0;
    bit fin = 0;
    logic s, r, d, c;
    logic [15:0] st, dn;
    ready_delay = 0; done_lat = 1;
    request(6, 1, 16'd6, 16'd6, 1'b0);
    for (int i = 0; i < 60 && !fin; i++) begin
      @(negedge ap_clk);
      #1;
      if (run_done) begin
        fin = 1;
      end else begin
        s = ch.child_ap_start; r = ch.child_ap_ready;
        d = ch.child_ap_done;  c = ch.child_ap_continue;
        st = starts_issued;    dn = dones_seen;
        @(posedge ap_clk);
        #1;
        if (s && r && d && c && (st - dn == 16'd2)) begin
          hits++;
          checks++;
          if (starts_issued !== st + 16'd1 || dones_seen !== dn + 16'd1) begin
            errors++;
            $display("FAIL overlap_counts: got %0d/%0d required %0d/%0d",
                     starts_issued, dones_seen, st + 16'd1, dn + 16'd1);
          end
        end
      end
    end
    checks++; if (hits == 0) begin errors++; $display("FAIL overlap_seen: got 0 overlap cycles required >0"); end
    checks++; if (!fin) begin errors++; $display("FAIL overlap_timeout: no run_done"); end
    @(posedge ap_clk);
    #1;
  endtask

  task automatic test_midrun_reset;
    bit saw_done = 0;
    acc_cyc.delete();
    ready_delay = 0; done_lat = 3;
    request(10, 0, 16'd0, 16'd0, 1'b0);
    for (int i = 0; i < 50 && acc_cyc.size() < 3; i++) @(negedge ap_clk);
    checks++; if (acc_cyc.size() < 3) begin errors++; $display("FAIL mid_progress: got %0d starts required 3", acc_cyc.size()); end
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    @(posedge ap_clk);
    #1;
    checks++; if (ch.child_ap_start !== 1'b0) begin errors++; $display("FAIL mid_start: got %b required 0", ch.child_ap_start); end
    checks++; if (run_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b required 1", run_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b required 0", busy); end
    checks++; if (starts_issued !== 16'd0) begin errors++; $display("FAIL mid_starts: got %0d required 0", starts_issued); end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      if (run_done) saw_done = 1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL mid_no_done: got run_done required none"); end
  endtask

`ifdef TESTENC_AP_CTRL_TIMEOUT_EN
  task automatic test_timeout;
    bit got = 0;
    int t_done = 0;
    acc_cyc.delete();
    ready_delay = 0; done_en = 0; tmo_limit = 20'd100;
    request(2, 1, 16'd2, 16'd0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      @(negedge ap_clk);
      if (run_done) begin
        got = 1;
        t_done = cyc;
        break;
      end
    end
    checks++;
    if (!got || acc_cyc.size() != 2) begin
      errors++;
      $display("FAIL tmo_run: done %0b starts %0d required 1 and 2", got, acc_cyc.size());
    end else begin
      checks++;
      if (t_done - acc_cyc[1] != 100) begin
        errors++;
        $display("FAIL tmo_latency: got %0d required 100", t_done - acc_cyc[1]);
      end
    end
    @(posedge ap_clk);
    #1;
    tmo_limit = 20'd0;
    done_en = 1;
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    ap_rst_n  = 1'b0;
    run_valid = 1'b0;
    run_count = 16'd0;
    tmo_limit = 20'd0;
    test_reset();
    test_spurious();
    test_zero_count();
    test_back_to_back();
    test_ready_stall();
    test_overlap();
    test_midrun_reset();
`ifdef TESTENC_AP_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge ap_clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending runs required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
